pipeline_hazard_ctrl: RTL and testbench

Front-end pipeline controller for the 5-stage MIPS core. It drives the IF stage's PC-hold, IF/ID-enable and branch-redirect controls, and injects ID/EX bubbles. It detects load-use hazards, squashes wrong-path instructions on taken branches, freezes the pipe while data memory is busy, and runs a drain/halt sequence for debug. It sits between the ID/EX hazard sources and the IF stage, and keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller for the 5-stage MIPS core.
// Handles load-use stalls, branch squash, dmem freeze and a debug drain/halt sequence.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_hold,
    output logic             if_reg_en,
    output logic             branch_taken,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state;
    logic [3:0] drainCnt;
    logic       loadUse;
    logic       stallEvt;
    logic       flushEvt;

    assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Reset values are forced here so the outputs follow rst_n without waiting for a clock.
    always_comb begin
        pc_hold      = 1'b1;
        if_reg_en    = 1'b0;
        branch_taken = 1'b0;
        idex_bubble  = 1'b1;
        pipe_freeze  = 1'b0;
        halted       = 1'b0;
        stallEvt     = 1'b0;
        flushEvt     = 1'b0;
        if (rst_n) begin
            if (state == HALTED) begin
                halted = 1'b1;
            end else if (dmem_busy) begin
                idex_bubble = 1'b0;
                pipe_freeze = 1'b1;
                stallEvt    = 1'b1;
            end else if (ex_branch_taken) begin
                pc_hold      = 1'b0;
                if_reg_en    = 1'b1;
                branch_taken = 1'b1;
                flushEvt     = 1'b1;
            end else if (state == RUN && loadUse) begin
                stallEvt = 1'b1;
            end else if (state == RUN) begin
                pc_hold     = 1'b0;
                if_reg_en   = 1'b1;
                idex_bubble = 1'b0;
            end
        end
    end

    // Drain only counts down on plain bubble cycles; freezes and redirects stretch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req && !dmem_busy) begin
                        state    <= DRAIN;
                        drainCnt <= 4'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!dmem_busy && !ex_branch_taken) begin
                        drainCnt <= drainCnt - 4'd1;
                        if (drainCnt == 4'd1)
                            state <= HALTED;
                    end
                end
                HALTED: begin
                    if (resume)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stallEvt && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (flushEvt && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken, dmem_busy, halt_req, resume;
    logic        pc_hold, if_reg_en, branch_taken, idex_bubble, pipe_freeze, halted;
    logic [15:0] stall_count, flush_count;

    int compared   = 0;
    int mismatched = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .halt_req(halt_req), .resume(resume),
        .pc_hold(pc_hold), .if_reg_en(if_reg_en), .branch_taken(branch_taken),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        dmem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIdle();
        repeat (2) tick();
        rst_n = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (2) tick();
        compared++;
        if (flush_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_flush: got %0d expected 2", flush_count);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({pc_hold, if_reg_en, branch_taken, idex_bubble, pipe_freeze, halted} !== 6'b100100) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected 100100",
                     {pc_hold, if_reg_en, branch_taken, idex_bubble, pipe_freeze, halted});
        end
        compared++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        tick();
        setIdle();
        rst_n = 1'b1;
        #1;
        compared++;
        if (pc_hold !== 1'b0 || if_reg_en !== 1'b1 || idex_bubble !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_run: got pc_hold=%b if_reg_en=%b bubble=%b expected 0 1 0",
                     pc_hold, if_reg_en, idex_bubble);
        end
        tick();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        compared++;
        if (pc_hold !== 1'b1 || if_reg_en !== 1'b0 || idex_bubble !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL lu_stall: got pc_hold=%b if_reg_en=%b bubble=%b expected 1 0 1",
                     pc_hold, if_reg_en, idex_bubble);
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        compared++;
        if (pc_hold !== 1'b0 || stall_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL lu_one_cycle: got pc_hold=%b stall=%0d expected 0 1", pc_hold, stall_count);
        end
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        compared++;
        if (pc_hold !== 1'b0 || idex_bubble !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lu_r0: got pc_hold=%b bubble=%b expected 0 0", pc_hold, idex_bubble);
        end
        tick();
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        compared++;
        if (pc_hold !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lu_rt_unused: got pc_hold=%b expected 0", pc_hold);
        end
        tick();
        id_uses_rt = 1'b1;
        #1;
        compared++;
        if (pc_hold !== 1'b1 || idex_bubble !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL lu_rt_used: got pc_hold=%b bubble=%b expected 1 1", pc_hold, idex_bubble);
        end
        tick();
        compared++;
        if (stall_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL lu_stall_count: got %0d expected 2", stall_count);
        end
    endtask

    task automatic test_branch_vs_lu();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; ex_branch_taken = 1'b1;
        #1;
        compared++;
        if ({branch_taken, pc_hold, if_reg_en, idex_bubble, pipe_freeze} !== 5'b10110) begin
            mismatched++;
            $display("[TB] FAIL branch_wins: got %b expected 10110",
                     {branch_taken, pc_hold, if_reg_en, idex_bubble, pipe_freeze});
        end
        tick();
        setIdle();
        compared++;
        if (flush_count !== 16'd1 || stall_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL branch_counts: got flush=%0d stall=%0d expected 1 2", flush_count, stall_count);
        end
    endtask

    task automatic test_freeze();
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({pipe_freeze, branch_taken, pc_hold, if_reg_en, idex_bubble} !== 5'b10100) begin
                mismatched++;
                $display("[TB] FAIL freeze_cycle%0d: got %b expected 10100", i,
                         {pipe_freeze, branch_taken, pc_hold, if_reg_en, idex_bubble});
            end
            tick();
        end
        dmem_busy = 1'b0;
        #1;
        compared++;
        if (branch_taken !== 1'b1 || pipe_freeze !== 1'b0 || stall_count !== 16'd5) begin
            mismatched++;
            $display("[TB] FAIL freeze_release: got br=%b frz=%b stall=%0d expected 1 0 5",
                     branch_taken, pipe_freeze, stall_count);
        end
        tick();
        setIdle();
        compared++;
        if (flush_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL freeze_flush: got %0d expected 2", flush_count);
        end
    endtask

    task automatic test_drain_halt();
        int drainLen;
        halt_req = 1'b1;
        #1;
        compared++;
        if (pc_hold !== 1'b0 || if_reg_en !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL halt_entry_run: got pc_hold=%b if_reg_en=%b expected 0 1", pc_hold, if_reg_en);
        end
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (pc_hold !== 1'b1 || idex_bubble !== 1'b1 || if_reg_en !== 1'b0 || halted !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL drain_cycle%0d: got hold=%b bub=%b en=%b halted=%b expected 1 1 0 0",
                         i, pc_hold, idex_bubble, if_reg_en, halted);
            end
            tick();
        end
        compared++;
        if (halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL halted_after_drain: got %b expected 1", halted);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        compared++;
        if (halted !== 1'b0 || pc_hold !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL resume_run: got halted=%b pc_hold=%b expected 0 0", halted, pc_hold);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        drainLen = 0;
        while (halted !== 1'b1 && drainLen < 20) begin
            dmem_busy = (drainLen == 1);
            drainLen++;
            tick();
        end
        dmem_busy = 1'b0;
        compared++;
        if (drainLen !== 5 || halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drain_extended: got %0d cycles halted=%b expected 5 1", drainLen, halted);
        end
        dmem_busy = 1'b1;
        #1;
        compared++;
        if (pipe_freeze !== 1'b0 || pc_hold !== 1'b1 || idex_bubble !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL halted_ignores_busy: got frz=%b hold=%b bub=%b expected 0 1 1",
                     pipe_freeze, pc_hold, idex_bubble);
        end
        tick();
        dmem_busy = 1'b0;
        compared++;
        if (stall_count !== 16'd6) begin
            mismatched++;
            $display("[TB] FAIL halted_stall_count: got %0d expected 6", stall_count);
        end
        resume = 1'b1; halt_req = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        compared++;
        if (halted !== 1'b0 || pc_hold !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL resume_halt_run: got halted=%b pc_hold=%b expected 0 0", halted, pc_hold);
        end
        tick();
        halt_req = 1'b0;
        #1;
        compared++;
        if (pc_hold !== 1'b1 || idex_bubble !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL redrain: got hold=%b bub=%b expected 1 1", pc_hold, idex_bubble);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        compared++;
        if (pc_hold !== 1'b0 || halted !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_drain: got hold=%b halted=%b expected 0 0", pc_hold, halted);
        end
    endtask

    task automatic test_saturation();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        compared++;
        if (flush_count !== 16'hFFFE) begin
            mismatched++;
            $display("[TB] FAIL flush_near_sat: got %0h expected fffe", flush_count);
        end
        repeat (5) tick();
        compared++;
        if (flush_count !== 16'hFFFF || stall_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL flush_saturated: got flush=%0h stall=%0d expected ffff 0",
                     flush_count, stall_count);
        end
        setIdle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_freeze();
        test_drain_halt();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
